// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: feeds an operand through a single-step shift unit
// once per clock until the requested amount is used up, then reports the result.
//
// state | meaning
// IDLE  | ready for a command; result/err hold the last outcome
// RUN   | one shift_unit step per edge, count tracks remaining steps
// DONE  | one-cycle done pulse, result/err valid
module shift_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [2:0]            cmd_op,
  input  logic [AMT_WIDTH-1:0]  cmd_amount,
  output logic [DATA_WIDTH-1:0] shift_in,
  output logic [2:0]            shift_lines,
  input  logic [DATA_WIDTH-1:0] shift_out,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  work;
  logic [2:0]             op;
  logic [AMT_WIDTH-1:0]   count;

  assign shift_in    = work;
  assign shift_lines = op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      work   <= '0;
      op     <= 3'd0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && ready) begin
            work  <= cmd_data;
            op    <= cmd_op;
            count <= cmd_amount;
            err   <= 1'b0;
            ready <= 1'b0;
            if (cmd_op == 3'd6 || cmd_op == 3'd7) begin
              err    <= 1'b1;
              result <= cmd_data;
              done   <= 1'b1;
              state  <= DONE;
            end else if (cmd_amount == '0) begin
              result <= cmd_data;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          work  <= shift_out;
          count <= count - AMT_WIDTH'(1);
          // Leaving on the last step means count never wraps below zero.
          if (count == AMT_WIDTH'(1)) begin
            result <= shift_out;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
